fb_mem_arbiter: RTL and testbench

//  Shares one single-port framebuffer RAM (1-cycle read latency) between the VGA scanout and the host.
//  - Scanout: requests one line prefetch per scanline, copied into the line buffer that feeds red/green/blue_out.
//  - Host: pixel writes from the AVR side.
//  - Scanout fetch has strict priority; host writes are queued in a small FIFO and drained in idle gaps.

---
 rtl/fb_mem_arbiter_if.sv | 25 ++
 rtl/fb_mem_arbiter.sv | 238 +++++++++++++++++++++++
 tb/tb_fb_mem_arbiter.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fb_mem_arbiter_if.sv
// Host pixel-write channel and single-port framebuffer RAM bus of fb_mem_arbiter.
// The arbiter connects through the slave modport; host and RAM model use master.
interface fb_mem_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
) ();
    logic              host_wr_valid;
    logic              host_wr_ready;
    logic [ADDR_W-1:0] host_wr_addr;
    logic [DATA_W-1:0] host_wr_data;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    modport master (
        output host_wr_valid, host_wr_addr, host_wr_data, ram_rdata,
        input  host_wr_ready, ram_addr, ram_we, ram_wdata
    );

    modport slave (
        input  host_wr_valid, host_wr_addr, host_wr_data, ram_rdata,
        output host_wr_ready, ram_addr, ram_we, ram_wdata
    );
endinterface

// File: rtl/fb_mem_arbiter.sv
// Framebuffer RAM arbiter: scanout line prefetch has strict priority, host writes
// are queued in a small FIFO and drained in idle gaps. Optional stats: FB_ARB_STATS_EN.
module fb_mem_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 8,
    parameter int LINE_WORDS = 200,
    parameter int LB_ADDR_W  = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 disp_req,
    input  logic [9:0]           disp_line,
    output logic                 fetch_done,
    output logic                 fetch_overrun,
    output logic                 lb_we,
    output logic [LB_ADDR_W-1:0] lb_addr,
    output logic [DATA_W-1:0]    lb_data,
    fb_mem_arbiter_if.slave      bus,
    output logic                 busy
`ifdef FB_ARB_STATS_EN
    ,
    output logic [15:0]          overrun_count,
    output logic [15:0]          host_stall_count
`endif
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FETCH   = 2'd1,
        ST_DRAIN   = 2'd2,
        ST_HOST_WR = 2'd3
    } state_t;

    state_t state_r;
    state_t state_next;

    logic [ADDR_W-1:0]    fifo_addr_r [FIFO_DEPTH];
    logic [DATA_W-1:0]    fifo_data_r [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_r;
    logic [PTR_W-1:0]     rd_ptr_r;
    logic [CNT_W-1:0]     fifo_cnt_r;
    logic                 fifo_full_s;
    logic                 fifo_empty_s;
    logic                 ready_s;
    logic                 push_s;
    logic                 pop_s;
    logic                 fetch_start_s;
    logic                 last_s;
    logic                 overrun_s;
    logic [ADDR_W-1:0]    base_s;

    logic [ADDR_W-1:0]    ram_addr_r;
    logic                 ram_we_r;
    logic [DATA_W-1:0]    ram_wdata_r;
    logic [LB_ADDR_W-1:0] cnt_r;
    logic                 lb_we_r;
    logic [LB_ADDR_W-1:0] lb_addr_r;
    logic                 fetch_done_r;
    logic                 fetch_overrun_r;
    logic                 busy_r;

    assign fifo_full_s   = (fifo_cnt_r == CNT_W'(FIFO_DEPTH));
    assign fifo_empty_s  = (fifo_cnt_r == {CNT_W{1'b0}});
    assign ready_s       = !rst && !fifo_full_s;
    assign push_s        = bus.host_wr_valid && ready_s;
    assign last_s        = (cnt_r == LB_ADDR_W'(LINE_WORDS - 1));
    assign overrun_s     = disp_req && ((state_r == ST_FETCH) || (state_r == ST_DRAIN));
    assign base_s        = ADDR_W'(32'(disp_line) * 32'(LINE_WORDS));

    assign bus.host_wr_ready = ready_s;
    assign bus.ram_addr      = ram_addr_r;
    assign bus.ram_we        = ram_we_r;
    assign bus.ram_wdata     = ram_wdata_r;
    assign lb_we             = lb_we_r;
    assign lb_addr           = lb_addr_r;
    assign fetch_done        = fetch_done_r;
    assign fetch_overrun     = fetch_overrun_r;
    assign busy              = busy_r;
    // The RAM's own read register supplies the data; gating keeps lb_data 0 outside a write.
    assign lb_data           = lb_we_r ? bus.ram_rdata : {DATA_W{1'b0}};

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next;
        end
    end

    // Next-state logic; a new fetch is only accepted from IDLE or between host writes.
    always_comb begin
        state_next    = state_r;
        pop_s         = 1'b0;
        fetch_start_s = 1'b0;
        case (state_r)
            ST_IDLE, ST_HOST_WR: begin
                if (disp_req) begin
                    state_next    = ST_FETCH;
                    fetch_start_s = 1'b1;
                end else if (!fifo_empty_s) begin
                    state_next = ST_HOST_WR;
                    pop_s      = 1'b1;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (last_s) begin
                    state_next = ST_DRAIN;
                end else begin
                    state_next = ST_FETCH;
                end
            end
            ST_DRAIN: begin
                if (!fifo_empty_s) begin
                    state_next = ST_HOST_WR;
                    pop_s      = 1'b1;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Host write FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r   <= {PTR_W{1'b0}};
            rd_ptr_r   <= {PTR_W{1'b0}};
            fifo_cnt_r <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1'b1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   fifo_cnt_r <= fifo_cnt_r + CNT_W'(1'b1);
                2'b01:   fifo_cnt_r <= fifo_cnt_r - CNT_W'(1'b1);
                default: fifo_cnt_r <= fifo_cnt_r;
            endcase
        end
    end

    // Host write FIFO storage.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_addr_r[i] <= {ADDR_W{1'b0}};
                fifo_data_r[i] <= {DATA_W{1'b0}};
            end
        end else if (push_s) begin
            fifo_addr_r[wr_ptr_r] <= bus.host_wr_addr;
            fifo_data_r[wr_ptr_r] <= bus.host_wr_data;
        end else begin
            fifo_addr_r <= fifo_addr_r;
            fifo_data_r <= fifo_data_r;
        end
    end

    // RAM command, line-buffer write and status pulses; line-buffer writes trail reads by one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            ram_addr_r      <= {ADDR_W{1'b0}};
            ram_we_r        <= 1'b0;
            ram_wdata_r     <= {DATA_W{1'b0}};
            cnt_r           <= {LB_ADDR_W{1'b0}};
            lb_we_r         <= 1'b0;
            lb_addr_r       <= {LB_ADDR_W{1'b0}};
            fetch_done_r    <= 1'b0;
            fetch_overrun_r <= 1'b0;
            busy_r          <= 1'b0;
        end else begin
            ram_we_r    <= pop_s;
            ram_wdata_r <= pop_s ? fifo_data_r[rd_ptr_r] : {DATA_W{1'b0}};
            if (fetch_start_s) begin
                ram_addr_r <= base_s;
                cnt_r      <= {LB_ADDR_W{1'b0}};
            end else if ((state_r == ST_FETCH) && !last_s) begin
                ram_addr_r <= ram_addr_r + ADDR_W'(1'b1);
                cnt_r      <= cnt_r + LB_ADDR_W'(1'b1);
            end else if (pop_s) begin
                ram_addr_r <= fifo_addr_r[rd_ptr_r];
                cnt_r      <= {LB_ADDR_W{1'b0}};
            end else begin
                ram_addr_r <= {ADDR_W{1'b0}};
                cnt_r      <= {LB_ADDR_W{1'b0}};
            end
            lb_we_r         <= (state_r == ST_FETCH);
            lb_addr_r       <= (state_r == ST_FETCH) ? cnt_r : {LB_ADDR_W{1'b0}};
            fetch_done_r    <= (state_r == ST_FETCH) && last_s;
            fetch_overrun_r <= overrun_s;
            busy_r          <= (state_next != ST_IDLE);
        end
    end

`ifdef FB_ARB_STATS_EN
    logic [15:0] overrun_cnt_r;
    logic [15:0] stall_cnt_r;
    logic        stall_s;

    assign stall_s          = bus.host_wr_valid && !ready_s;
    assign overrun_count    = overrun_cnt_r;
    assign host_stall_count = stall_cnt_r;

    // Saturating overrun and host-stall counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            overrun_cnt_r <= 16'h0000;
            stall_cnt_r   <= 16'h0000;
        end else begin
            if (overrun_s && (overrun_cnt_r != 16'hFFFF)) begin
                overrun_cnt_r <= overrun_cnt_r + 16'h0001;
            end else begin
                overrun_cnt_r <= overrun_cnt_r;
            end
            if (stall_s && (stall_cnt_r != 16'hFFFF)) begin
                stall_cnt_r <= stall_cnt_r + 16'h0001;
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fb_mem_arbiter.sv
// Directed-vector bench for fb_mem_arbiter: line fetch timing, host writes,
// preemption, overrun, FIFO full and reset mid-fetch.
module tb_fb_mem_arbiter;
    logic       clk;
    logic       rst;
    logic       disp_req;
    logic [9:0] disp_line;
    logic       fetch_done;
    logic       fetch_overrun;
    logic       lb_we;
    logic [7:0] lb_addr;
    logic [7:0] lb_data;
    logic       busy;
`ifdef FB_ARB_STATS_EN
    logic [15:0] overrun_count;
    logic [15:0] host_stall_count;
`endif

    int n_vec = 0;
    int n_err = 0;
    int n_acc = 0;
    logic [23:0] host_todo [$];
    logic [23:0] exp_q [$];
    logic [23:0] wlog [$];

    fb_mem_arbiter_if #(.ADDR_W(16), .DATA_W(8)) bus ();

    fb_mem_arbiter dut (
        .clk              (clk),
        .rst              (rst),
        .disp_req         (disp_req),
        .disp_line        (disp_line),
        .fetch_done       (fetch_done),
        .fetch_overrun    (fetch_overrun),
        .lb_we            (lb_we),
        .lb_addr          (lb_addr),
        .lb_data          (lb_data),
        .bus              (bus),
        .busy             (busy)
`ifdef FB_ARB_STATS_EN
        ,
        .overrun_count    (overrun_count),
        .host_stall_count (host_stall_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: read data is the low byte of the address, one cycle later.
    always @(posedge clk) bus.ram_rdata <= bus.ram_addr[7:0];

    // Log every RAM write seen on the bus.
    always @(negedge clk) begin
        if (bus.ram_we === 1'b1) wlog.push_back({bus.ram_addr, bus.ram_wdata});
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
        end
    endtask

    task automatic host_load();
        logic [23:0] e;
        if (host_todo.size() > 0) begin
            e = host_todo.pop_front();
            bus.host_wr_valid = 1'b1;
            bus.host_wr_addr  = e[23:8];
            bus.host_wr_data  = e[7:0];
        end else begin
            bus.host_wr_valid = 1'b0;
        end
    endtask

    task automatic host_queue(input logic [15:0] a, input logic [7:0] d);
        host_todo.push_back({a, d});
        exp_q.push_back({a, d});
    endtask

    // One clock: note a handshake before the edge, then move to #1 after it.
    task automatic step();
        logic acc;
        acc = bus.host_wr_valid && bus.host_wr_ready;
        @(posedge clk);
        #1;
        if (acc) begin
            n_acc++;
            host_load();
        end
    endtask

    task automatic start_fetch(input int line);
        disp_req  = 1'b1;
        disp_line = 10'(line);
        step();
        disp_req  = 1'b0;
    endtask

    // Checks fetch cycles 1..201 after the disp_req edge; ends in cycle 202.
    task automatic follow_fetch(input int line, input int ovr_at, input int ready_until);
        int base;
        int lbc;
        base = (line * 200) & 32'hFFFF;
        lbc  = 0;
        for (int k = 1; k <= 201; k++) begin
            if (k <= 200) check_eq("fetch_addr", 32'(bus.ram_addr), 32'(base + k - 1));
            check_eq("fetch_ram_we", 32'(bus.ram_we), 32'd0);
            check_eq("fetch_busy", 32'(busy), 32'd1);
            check_eq("lb_we", 32'(lb_we), 32'(k >= 2));
            if (k >= 2) begin
                check_eq("lb_addr", 32'(lb_addr), 32'(k - 2));
                check_eq("lb_data", 32'(lb_data), 32'((base + k - 2) & 255));
            end
            if (lb_we === 1'b1) lbc++;
            check_eq("fetch_done", 32'(fetch_done), 32'(k == 201));
            check_eq("fetch_overrun", 32'(fetch_overrun), 32'(k == ovr_at + 1));
            if (ready_until >= 0) check_eq("host_ready", 32'(bus.host_wr_ready), 32'(k <= ready_until));
            if (k == ovr_at) begin
                disp_req  = 1'b1;
                disp_line = 10'(line + 1);
            end else begin
                disp_req = 1'b0;
            end
            step();
        end
        check_eq("lb_we_count", 32'(lbc), 32'd200);
    endtask

    task automatic wait_idle();
        for (int c = 0; c < 400; c++) begin
            if (!busy && !bus.host_wr_valid) break;
            step();
        end
        check_eq("idle_timeout", 32'(busy || bus.host_wr_valid), 32'd0);
    endtask

    task automatic check_writes(input string tag);
        check_eq({tag, "_count"}, 32'(wlog.size()), 32'(exp_q.size()));
        for (int j = 0; j < exp_q.size() && j < wlog.size(); j++) begin
            check_eq(tag, 32'(wlog[j]), 32'(exp_q[j]));
        end
        wlog.delete();
        exp_q.delete();
    endtask

    initial begin
        int fd;
        int wv;
        rst               = 1'b1;
        disp_req          = 1'b0;
        disp_line         = 10'd0;
        bus.host_wr_valid = 1'b0;
        bus.host_wr_addr  = 16'h0000;
        bus.host_wr_data  = 8'h00;
        repeat (3) step();
        check_eq("rst_ready", 32'(bus.host_wr_ready), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_ram_we", 32'(bus.ram_we), 32'd0);
        check_eq("rst_lb_we", 32'(lb_we), 32'd0);
        check_eq("rst_fetch_done", 32'(fetch_done), 32'd0);
        rst = 1'b0;
        #1;
        check_eq("post_rst_ready", 32'(bus.host_wr_ready), 32'd1);
        step();

        // 1: line 3 fetch, base 600
        start_fetch(3);
        follow_fetch(3, -10, -1);
        check_eq("t1_busy_after", 32'(busy), 32'd0);
        wait_idle();
        check_writes("t1_writes");

        // 2: two host writes while idle
        host_queue(16'h1234, 8'hAB);
        host_queue(16'h1235, 8'hCD);
        host_load();
        step();
        step();
        check_eq("t2_w0", 32'({bus.ram_we, bus.ram_addr, bus.ram_wdata}), 32'h0_1_1234_AB);
        check_eq("t2_busy", 32'(busy), 32'd1);
        step();
        check_eq("t2_w1", 32'({bus.ram_we, bus.ram_addr, bus.ram_wdata}), 32'h0_1_1235_CD);
        step();
        check_eq("t2_we_off", 32'(bus.ram_we), 32'd0);
        check_eq("t2_busy_off", 32'(busy), 32'd0);
        check_writes("t2_writes");

        // 3: fetch request on the second HOST_WR cycle
        for (int j = 0; j < 4; j++) host_queue(16'(16'h2000 + j), 8'(8'h10 + j));
        host_load();
        step();
        step();
        check_eq("t3_w0", 32'({bus.ram_we, bus.ram_addr, bus.ram_wdata}), 32'h0_1_2000_10);
        step();
        check_eq("t3_w1", 32'({bus.ram_we, bus.ram_addr, bus.ram_wdata}), 32'h0_1_2001_11);
        disp_req  = 1'b1;
        disp_line = 10'd2;
        step();
        disp_req  = 1'b0;
        follow_fetch(2, -10, -1);
        check_eq("t3_w2", 32'({bus.ram_we, bus.ram_addr, bus.ram_wdata}), 32'h0_1_2002_12);
        step();
        check_eq("t3_w3", 32'({bus.ram_we, bus.ram_addr, bus.ram_wdata}), 32'h0_1_2003_13);
        step();
        check_eq("t3_busy_off", 32'(busy), 32'd0);
        wait_idle();
        check_writes("t3_writes");

        // 4: second request 50 cycles into a fetch of line 5 (base 1000)
        start_fetch(5);
        follow_fetch(5, 50, -1);
        check_eq("t4_no_refetch", 32'(busy), 32'd0);
`ifdef FB_ARB_STATS_EN
        check_eq("t4_overrun_count", 32'(overrun_count), 32'd1);
`endif
        wait_idle();
        check_writes("t4_writes");

        // 5: host holds valid through a fetch of line 10; FIFO fills at 4
        for (int j = 0; j < 5; j++) host_queue(16'(16'h4000 + 3 * j), 8'(8'h50 + j));
        n_acc = 0;
        host_load();
        start_fetch(10);
        follow_fetch(10, -10, 3);
        check_eq("t5_accepted", 32'(n_acc), 32'd4);
        check_eq("t5_ready_after", 32'(bus.host_wr_ready), 32'd1);
`ifdef FB_ARB_STATS_EN
        check_eq("t5_stall_count", 32'(host_stall_count), 32'd198);
`endif
        wait_idle();
        check_writes("t5_writes");

        // 6: reset at word 100 of a line 4 fetch with writes queued
        host_queue(16'h6000, 8'h66);
        host_queue(16'h6001, 8'h67);
        host_load();
        start_fetch(4);
        for (int k = 1; k <= 100; k++) step();
        check_eq("t6_word100", 32'(bus.ram_addr), 32'd900);
        rst               = 1'b1;
        bus.host_wr_valid = 1'b0;
        host_todo.delete();
        exp_q.delete();
        step();
        check_eq("t6_ram", 32'({bus.ram_we, bus.ram_addr, bus.ram_wdata}), 32'd0);
        check_eq("t6_lb", 32'({lb_we, lb_addr, lb_data}), 32'd0);
        check_eq("t6_flags", 32'({fetch_done, fetch_overrun, busy, bus.host_wr_ready}), 32'd0);
`ifdef FB_ARB_STATS_EN
        check_eq("t6_overrun_count", 32'(overrun_count), 32'd0);
        check_eq("t6_stall_count", 32'(host_stall_count), 32'd0);
`endif
        rst = 1'b0;
        #1;
        check_eq("t6_ready", 32'(bus.host_wr_ready), 32'd1);
        fd = 0;
        wv = 0;
        for (int k = 0; k < 210; k++) begin
            step();
            if (fetch_done === 1'b1) fd++;
            if (bus.ram_we === 1'b1 || busy === 1'b1) wv++;
        end
        check_eq("t6_no_fetch_done", 32'(fd), 32'd0);
        check_eq("t6_no_activity", 32'(wv), 32'd0);
        check_writes("t6_writes");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
